// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and encodings for the memory port arbiter:
//   FSM states, requester IDs, access-size encodings and the
//   alignment check used both at grant time and by the lane formatter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MPA_IDLE = 2'd0,
    MPA_BUS  = 2'd1,
    MPA_RESP = 2'd2
  } mpa_state_e;

  typedef enum logic {
    MPA_REQ_IF = 1'b0,
    MPA_REQ_LS = 1'b1
  } mpa_req_e;

  // Access size field: bit2 = unsigned load, [1:0] = width
  localparam logic [1:0]  MEM_B            = 2'b00;
  localparam logic [1:0]  MEM_H            = 2'b01;
  localparam logic [1:0]  MEM_W            = 2'b10;
  localparam int unsigned MEM_UNSIGNED_BIT = 2;

  // High for a half on an odd address, a word off a word boundary,
  // or the illegal width encoding.
  function automatic logic mpa_misaligned(input logic [1:0] addr,
                                          input logic [1:0] width);
    logic r;
    case (width)
      MEM_B:   r = 1'b0;
      MEM_H:   r = addr[0];
      MEM_W:   r = (addr != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_format.sv
// mem_lane_format
//   Purely combinational byte-lane formatter.
//   i_addr       : byte offset within the word
//   i_size       : access size (bit2 unsigned, [1:0] width)
//   i_wdata      : right-aligned store data
//   i_bus_rdata  : raw word returned by the slave
//   o_wstrb      : byte strobes for a store of this size/offset
//   o_wdata      : store data replicated onto every candidate lane
//   o_rdata      : selected load data, sign- or zero-extended
//   o_misaligned : access is misaligned or uses the illegal width
module mem_lane_format
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_size,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_bus_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    w_byte       = i_bus_rdata[{i_addr, 3'b000} +: 8];
    w_half       = i_addr[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    w_sext       = ~i_size[MEM_UNSIGNED_BIT];
    o_wstrb      = '0;
    o_wdata      = '0;
    o_rdata      = '0;
    o_misaligned = mpa_misaligned(i_addr, i_size[1:0]);
    case (i_size[1:0])
      MEM_B: begin
        o_wstrb = 4'b0001 << i_addr;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_sext & w_byte[7]}}, w_byte};
      end
      MEM_H: begin
        o_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_sext & w_half[15]}}, w_half};
      end
      MEM_W: begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_bus_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory bus between instruction fetch (IF) and the
//   load/store unit (LS): round-robin grant, lane steering, load
//   extension, misalignment rejection and slave-timeout errors.
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     if_req/if_addr                   IF word-read request (level)
//     if_rsp_valid/if_rdata/if_err     IF one-cycle response
//     ls_req/ls_we/ls_addr/ls_wdata/ls_u_b_h_w  LS request (level)
//     ls_rsp_valid/ls_rdata/ls_err     LS one-cycle response
//     bus_req/bus_we/bus_addr/bus_wstrb/bus_wdata  bus master side
//     bus_ack/bus_rdata                slave completion and read data
//     busy                             FSM not idle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_u_b_h_w,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mpa_state_e    r_state, w_state_nxt;
  mpa_req_e      r_last, r_id, w_grant;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic [2:0]    r_size;
  logic          r_we, r_err;
  logic [CW-1:0] r_cnt;

  logic          w_any, w_timeout;
  logic [31:0]   w_sel_addr, w_sel_wdata;
  logic [2:0]    w_sel_size;
  logic          w_sel_we;
  logic [1:0]    w_fmt_addr;
  logic [2:0]    w_fmt_size;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata, w_rdata, w_rsp_data;
  logic          w_misaligned;

  // LS wins a tie only when IF was granted last.
  always_comb begin
    w_any       = if_req | ls_req;
    w_grant     = (ls_req & (~if_req | (r_last == MPA_REQ_IF))) ? MPA_REQ_LS : MPA_REQ_IF;
    w_sel_addr  = (w_grant == MPA_REQ_LS) ? ls_addr : if_addr;
    w_sel_size  = (w_grant == MPA_REQ_LS) ? ls_u_b_h_w : {1'b0, MEM_W};
    w_sel_we    = (w_grant == MPA_REQ_LS) & ls_we;
    w_sel_wdata = (w_grant == MPA_REQ_LS) ? ls_wdata : '0;
    w_timeout   = (r_cnt == CNT_LAST);
    // The formatter sees the live granted request while idle so the
    // misalignment decision is made in the grant cycle; otherwise it
    // works from the latched fields.
    w_fmt_addr  = (r_state == MPA_IDLE) ? w_sel_addr[1:0] : r_addr[1:0];
    w_fmt_size  = (r_state == MPA_IDLE) ? w_sel_size : r_size;
  end

  mem_lane_format u_lane (
    .i_addr       (w_fmt_addr),
    .i_size       (w_fmt_size),
    .i_wdata      (r_wdata),
    .i_bus_rdata  (r_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MPA_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MPA_IDLE: if (w_any) w_state_nxt = w_misaligned ? MPA_RESP : MPA_BUS;
      MPA_BUS:  if (bus_ack || w_timeout) w_state_nxt = MPA_RESP;
      MPA_RESP: w_state_nxt = MPA_IDLE;
      default:  w_state_nxt = MPA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= MPA_REQ_IF;
      r_id    <= MPA_REQ_IF;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MPA_IDLE: if (w_any) begin
          r_id    <= w_grant;
          r_last  <= w_grant;
          r_addr  <= w_sel_addr;
          r_size  <= w_sel_size;
          r_we    <= w_sel_we;
          r_wdata <= w_sel_wdata;
          r_rdata <= '0;
          r_err   <= w_misaligned;
          r_cnt   <= '0;
        end
        MPA_BUS: begin
          // Ack takes priority over a timeout in the same cycle.
          if (bus_ack) begin
            r_rdata <= bus_rdata;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy         = (r_state != MPA_IDLE);
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_wstrb    = '0;
    bus_wdata    = '0;
    if_rsp_valid = 1'b0;
    if_rdata     = '0;
    if_err       = 1'b0;
    ls_rsp_valid = 1'b0;
    ls_rdata     = '0;
    ls_err       = 1'b0;
    w_rsp_data   = (r_err || r_we) ? '0 : w_rdata;
    case (r_state)
      MPA_BUS: begin
        bus_req   = 1'b1;
        bus_we    = r_we;
        bus_addr  = {r_addr[31:2], 2'b00};
        bus_wstrb = r_we ? w_wstrb : '0;
        bus_wdata = r_we ? w_wdata : '0;
      end
      MPA_RESP: begin
        if (r_id == MPA_REQ_LS) begin
          ls_rsp_valid = 1'b1;
          ls_rdata     = w_rsp_data;
          ls_err       = r_err;
        end else begin
          if_rsp_valid = 1'b1;
          if_rdata     = w_rsp_data;
          if_err       = r_err;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with TIMEOUT = 4 and a
//   behavioural slave whose wait states and read data are set per test.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [2:0]  ls_u_b_h_w;
  logic        ls_rsp_valid;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        busy;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rdata     (if_rdata),
    .if_err       (if_err),
    .ls_req       (ls_req),
    .ls_we        (ls_we),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .ls_u_b_h_w   (ls_u_b_h_w),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rdata     (ls_rdata),
    .ls_err       (ls_err),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wstrb    (bus_wstrb),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Slave: acks after slv_wait extra BUS cycles, returns bus_addr ^ slv_key.
  // With late_ack set it also holds ack high whenever bus_req is low.
  int          slv_wait = 0;
  logic [31:0] slv_key  = '0;
  bit          late_ack = 1'b0;

  initial begin
    int wcnt;
    wcnt      = 0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        if (wcnt >= slv_wait) begin
          bus_ack   = 1'b1;
          bus_rdata = bus_addr ^ slv_key;
        end else begin
          bus_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus_ack   = late_ack;
        bus_rdata = '0;
        wcnt      = 0;
      end
    end
  end

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_we;

  // Issue one request from a negedge; latency is counted in cycles from
  // the edge that first sees the request (1 = misaligned, 2 + waits).
  task automatic do_txn(input bit ls, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size,
                        input int wt, input logic [31:0] exp_rd, input bit exp_err,
                        input int exp_lat, input string tag);
    int lat, reqc;
    bit other;
    lat = 0; reqc = 0; other = 1'b0;
    slv_wait = wt;
    if (ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_u_b_h_w = size;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus_req) begin
        reqc++;
        cap_addr = bus_addr; cap_wdata = bus_wdata; cap_wstrb = bus_wstrb; cap_we = bus_we;
      end
      if (ls ? if_rsp_valid : ls_rsp_valid) other = 1'b1;
      if (ls ? ls_rsp_valid : if_rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk_eq({tag, " latency"}, lat, exp_lat);
    chk_eq({tag, " bus_req_cycles"}, reqc, exp_lat - 1);
    chk_eq({tag, " rdata"}, ls ? ls_rdata : if_rdata, exp_rd);
    chk_eq({tag, " err"}, 32'(ls ? ls_err : if_err), 32'(exp_err));
    chk_eq({tag, " other_rsp"}, 32'(other), 32'(0));
    if (ls) ls_req = 1'b0;
    else    if_req = 1'b0;
    @(negedge clk);
    chk_eq({tag, " rsp_single"}, 32'(ls ? ls_rsp_valid : if_rsp_valid), 32'(0));
    chk_eq({tag, " idle_after"}, 32'(busy), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_u_b_h_w = '0;
    cap_addr = '0; cap_wdata = '0; cap_wstrb = '0; cap_we = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk_eq("rst bus_req",   32'(bus_req), 32'(0));
    chk_eq("rst bus_we",    32'(bus_we), 32'(0));
    chk_eq("rst bus_addr",  bus_addr, 32'h0);
    chk_eq("rst bus_wstrb", 32'(bus_wstrb), 32'(0));
    chk_eq("rst bus_wdata", bus_wdata, 32'h0);
    chk_eq("rst rsp_valid", 32'({if_rsp_valid, ls_rsp_valid}), 32'(0));
    chk_eq("rst rdata_or",  if_rdata | ls_rdata, 32'h0);
    chk_eq("rst err",       32'({if_err, ls_err}), 32'(0));
    chk_eq("rst busy",      32'(busy), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesters continuously active from reset: LS, IF, LS, IF
    slv_wait = 0;
    slv_key  = 32'hA5A5_0000;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0200; ls_u_b_h_w = 3'b010;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk_eq($sformatf("rr c%0d ls_rsp", k), 32'(ls_rsp_valid), 32'((k == 2) || (k == 8)));
      chk_eq($sformatf("rr c%0d if_rsp", k), 32'(if_rsp_valid), 32'((k == 5) || (k == 11)));
      if ((k == 2) || (k == 8))  chk_eq($sformatf("rr c%0d ls_rdata", k), ls_rdata, 32'hA5A5_0200);
      if ((k == 5) || (k == 11)) chk_eq($sformatf("rr c%0d if_rdata", k), if_rdata, 32'hA5A5_0100);
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    chk_eq("rr idle", 32'(busy), 32'(0));

    // sb at 0x1003, zero-wait
    do_txn(1'b1, 1'b1, 32'h0000_1003, 32'h0000_00A5, 3'b000, 0, 32'h0, 1'b0, 2, "sb");
    chk_eq("sb bus_addr",  cap_addr, 32'h0000_1000);
    chk_eq("sb bus_wstrb", 32'(cap_wstrb), 32'(4'b1000));
    chk_eq("sb bus_wdata", cap_wdata, 32'hA5A5_A5A5);
    chk_eq("sb bus_we",    32'(cap_we), 32'(1));

    // Loads from word 0x2000 holding 0x80011234
    slv_key = 32'h8001_1234 ^ 32'h0000_2000;
    do_txn(1'b1, 1'b0, 32'h0000_2002, 32'h0, 3'b001, 0, 32'hFFFF_8001, 1'b0, 2, "lh");
    chk_eq("lh bus_addr",  cap_addr, 32'h0000_2000);
    chk_eq("lh bus_wstrb", 32'(cap_wstrb), 32'(0));
    chk_eq("lh bus_we",    32'(cap_we), 32'(0));
    do_txn(1'b1, 1'b0, 32'h0000_2002, 32'h0, 3'b101, 0, 32'h0000_8001, 1'b0, 2, "lhu");
    do_txn(1'b1, 1'b0, 32'h0000_2003, 32'h0, 3'b000, 1, 32'hFFFF_FF80, 1'b0, 3, "lb");
    do_txn(1'b1, 1'b0, 32'h0000_2003, 32'h0, 3'b100, 0, 32'h0000_0080, 1'b0, 2, "lbu");
    do_txn(1'b1, 1'b0, 32'h0000_2000, 32'h0, 3'b000, 0, 32'h0000_0034, 1'b0, 2, "lb0");

    // sh upper half with one wait state
    do_txn(1'b1, 1'b1, 32'h0000_2006, 32'h0000_BEEF, 3'b001, 1, 32'h0, 1'b0, 3, "sh");
    chk_eq("sh bus_addr",  cap_addr, 32'h0000_2004);
    chk_eq("sh bus_wstrb", 32'(cap_wstrb), 32'(4'b1100));
    chk_eq("sh bus_wdata", cap_wdata, 32'hBEEF_BEEF);

    // sw whose ack lands on the last cycle before timeout
    do_txn(1'b1, 1'b1, 32'h0000_0030, 32'h1234_5678, 3'b010, 3, 32'h0, 1'b0, 5, "sw_w3");
    chk_eq("sw bus_wstrb", 32'(cap_wstrb), 32'(4'b1111));
    chk_eq("sw bus_wdata", cap_wdata, 32'h1234_5678);

    // IF fetch with two wait states
    slv_key = 32'hDEAD_0000;
    do_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 3'b010, 2, 32'hDEAD_0040, 1'b0, 4, "if_w2");

    // Misaligned / illegal accesses: no bus cycle, error in cycle 1
    do_txn(1'b1, 1'b0, 32'h0000_3001, 32'h0, 3'b010, 0, 32'h0, 1'b1, 1, "lw_mis");
    do_txn(1'b1, 1'b1, 32'h0000_3003, 32'h0, 3'b001, 0, 32'h0, 1'b1, 1, "sh_mis");
    do_txn(1'b1, 1'b0, 32'h0000_3000, 32'h0, 3'b011, 0, 32'h0, 1'b1, 1, "ill_size");
    do_txn(1'b0, 1'b0, 32'h0000_0102, 32'h0, 3'b010, 0, 32'h0, 1'b1, 1, "if_mis");

    // Slave never acks: 4 bus_req cycles then IF error; late ack ignored
    late_ack = 1'b1;
    do_txn(1'b0, 1'b0, 32'h0000_0400, 32'h0, 3'b010, 1000, 32'h0, 1'b1, 5, "if_tmo");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_eq($sformatf("late_ack c%0d rsp", k), 32'({if_rsp_valid, ls_rsp_valid}), 32'(0));
      chk_eq($sformatf("late_ack c%0d bus_req", k), 32'(bus_req), 32'(0));
    end
    late_ack = 1'b0;

    // Reset in the middle of a 3-wait LS transfer
    slv_key = '0;
    slv_wait = 3;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0500; ls_u_b_h_w = 3'b010;
    @(negedge clk);
    chk_eq("rst_mid bus_req_before", 32'(bus_req), 32'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rst_mid bus_req_async", 32'(bus_req), 32'(0));
    chk_eq("rst_mid busy_async", 32'(busy), 32'(0));
    ls_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_eq($sformatf("rst_mid c%0d rsp", k), 32'({if_rsp_valid, ls_rsp_valid}), 32'(0));
    end

    slv_key = 32'h1111_0000;
    do_txn(1'b1, 1'b0, 32'h0000_0600, 32'h0, 3'b010, 1, 32'h1111_0600, 1'b0, 3, "post_rst_lw");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
